video_scanner: RTL and testbench
================================

VIDEO_SCANNER -- requirements
Module: video_scanner

Interface
REQ-001 Parameter TEXT_BASE, default 16'h0400, is the byte address of text cell (row 0, col 0).
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 280/8/16/16 (H_TOTAL 320), are horizontal timing in pixel ticks.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 192/8/4/58 (V_TOTAL 262), are vertical timing in lines.
REQ-004 Port CLOCK_50  in  1  is the sole clock; all state changes on its rising edge.
REQ-005 Port res  in  1  is the reset: asynchronous, active-high.
REQ-006 Port vid_phi  in  1  is the pixel-tick enable, one CLOCK_50 cycle wide.
REQ-007 Port vid_adr  out  16  is the fetch address, stable while vid_req is high.
REQ-008 Port vid_req  out  1  is the fetch request.
REQ-009 Port vid_ack  in  1  is the fetch acknowledge; vid_dbi is valid in the same cycle.
REQ-010 Port vid_dbi  in  8  is the fetched character byte.
REQ-011 Port char_code  out  8  is the character for the current cell.
REQ-012 Port char_row  out  3  is the scanline within the cell (v[2:0]).
REQ-013 Port char_px  out  3  is the pixel within the cell, 0..6.
REQ-014 Ports hsync, vsync  out  1 each are the sync outputs, active-low.
REQ-015 Port blank  out  1  is high outside the active region.
REQ-016 Port underrun  out  1  is a sticky flag: a cell load found no fetched data.
REQ-017 Port frame_start  out  1  pulses for one CLOCK_50 cycle when h=0,v=0 is entered.

Function
REQ-018 Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance only on cycles with vid_phi=1; h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
REQ-019 All display outputs are registered and update on the same edge that advances the counters, reflecting the new h,v.
REQ-020 blank = !(h<H_ACTIVE && v<V_ACTIVE); hsync=0 for h in [288,304); vsync=0 for v in [200,204).
REQ-021 Cell column col = h/7 (0..39) and text row r = v>>3 (0..23); the row base address is held as a running register (+40 per text row), with no multiplier.
REQ-022 Fetch address = TEXT_BASE + r*40 + col, modulo 2^16.
REQ-023 Handshake: vid_req rises with vid_adr stable; the engine holds both until vid_ack=1; it captures vid_dbi into next_char, sets next_valid, and deasserts vid_req on the following cycle; vid_ack with vid_req low is ignored.
REQ-024 Fetch FSM states: IDLE, BUSY, DROP. IDLE->BUSY when a target cell is not yet fetched; BUSY->IDLE on ack (data kept); DROP->IDLE on ack (data discarded).
REQ-025 Prefetch: on the tick entering h=H_ACTIVE of a line whose successor line is active, the target becomes col 0 of that successor line; v=V_TOTAL-1 targets line 0.
REQ-026 Cell load: on each tick entering h%7==0 with h<H_ACTIVE and v<V_ACTIVE, char_code<=next_char and next_valid is cleared; the target becomes col+1 when col<39.
REQ-027 If next_valid=0 at a cell load, char_code<=8'h20, underrun<=1, and a BUSY fetch moves to DROP; the fetch for the new target is issued after the drop completes.
REQ-028 Simultaneous ack and cell load in one cycle: the acked data is loaded into char_code directly; no underrun is flagged.
REQ-029 char_code holds its value through blanking; char_px = h%7 and char_row = v[2:0] in the active region, and 0 otherwise.

Reset
REQ-030 While res=1: h=v=0, vid_req=0, vid_adr=TEXT_BASE, FSM=IDLE, next_valid=0, char_code=8'h20, char_row=char_px=0, hsync=vsync=1, blank=1, underrun=0, frame_start=0.
REQ-031 res asserted mid-handshake drops vid_req immediately; a late vid_ack after release is ignored.
REQ-032 underrun clears only on res.

Structure
REQ-033 Package vid_pkg holds the timing defaults, COLS=40, ROWS=24, CELL_W=7, and the fetch-state enum.
REQ-034 Sub-module vid_timing contains the h/v counters, sync and blank; video_scanner contains the fetch FSM and cell buffer.

Verification
REQ-035 res pulse, then vid_phi every 4 cycles for 1 frame -> 83,840 ticks between frame_start pulses; hsync low 16 ticks per line; vsync low 4 lines.
REQ-036 Memory model with ack after 2 cycles, byte = low address byte -> row 0 col 5 shows char_code 8'h05; row 1 col 0 fetches 16'h0428.
REQ-037 Ack delay 40 cycles with vid_phi every cycle -> char_code=8'h20 and underrun=1 at the first load; underrun stays high afterwards.
REQ-038 res asserted while vid_req=1 -> vid_req=0 within the same cycle; no capture occurs after release.
REQ-039 Ack forced on the exact cell-load cycle -> the acked byte appears on char_code and underrun stays 0.
REQ-040 TEXT_BASE=16'hFFF0 -> col 16 of row 0 fetches 16'h0000 (wrap).

Source files
------------

// File: rtl/vid_pkg.sv
// Shared timing defaults, text geometry and fetch-state type for the
// text-mode video scanner.
package vid_pkg;
   localparam int H_ACTIVE_DEF = 280;
   localparam int H_FP_DEF     = 8;
   localparam int H_SYNC_DEF   = 16;
   localparam int H_BP_DEF     = 16;
   localparam int V_ACTIVE_DEF = 192;
   localparam int V_FP_DEF     = 8;
   localparam int V_SYNC_DEF   = 4;
   localparam int V_BP_DEF     = 58;

   localparam int COLS   = 40;
   localparam int ROWS   = 24;
   localparam int CELL_W = 7;
   localparam int CNT_W  = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/vid_timing.sv
// Horizontal/vertical pixel-tick counters with registered sync, blank and
// frame-start outputs that always describe the counter values just entered.
module vid_timing
   import vid_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic             CLOCK_50,
   input  logic             res,
   input  logic             vid_phi,
   output logic [CNT_W-1:0] v,
   output logic [CNT_W-1:0] h_nxt,
   output logic [CNT_W-1:0] v_nxt,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic             frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] h;

   always_comb begin
      h_nxt = h;
      v_nxt = v;
      if (vid_phi) begin
         if (h == CNT_W'(H_TOTAL - 1)) begin
            h_nxt = '0;
            v_nxt = (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + CNT_W'(1);
         end else begin
            h_nxt = h + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge res) begin
      if (res) begin
         h           <= '0;
         v           <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= vid_phi && (h_nxt == '0) && (v_nxt == '0);
         if (vid_phi) begin
            h     <= h_nxt;
            v     <= v_nxt;
            hsync <= !((h_nxt >= CNT_W'(H_ACTIVE + H_FP)) &&
                       (h_nxt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
            vsync <= !((v_nxt >= CNT_W'(V_ACTIVE + V_FP)) &&
                       (v_nxt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
            blank <= !((h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE)));
         end
      end
   end
endmodule

// File: rtl/video_scanner.sv
// Text-mode scanner: walks the screen in pixel ticks, fetches one character
// byte ahead of the beam and loads it into char_code at each cell boundary.
module video_scanner
   import vid_pkg::*;
#(
   parameter logic [15:0] TEXT_BASE = 16'h0400,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic        CLOCK_50,
   input  logic        res,
   input  logic        vid_phi,
   output logic [15:0] vid_adr,
   output logic        vid_req,
   input  logic        vid_ack,
   input  logic [7:0]  vid_dbi,
   output logic [7:0]  char_code,
   output logic [2:0]  char_row,
   output logic [2:0]  char_px,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic        underrun,
   output logic        frame_start,
   output logic [1:0]  fetch_state
);
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] v, h_nxt, v_nxt;
   logic [2:0]       px_q, px_nxt;
   logic [5:0]       col_q, col_nxt;
   logic [15:0]      line_base, base_nxt, succ_base, tgt_adr, tgt_nxt;
   logic             need_fetch, next_valid;
   logic [7:0]       next_char;
   logic             active_nxt, cell_load, prefetch, new_tgt, ack_ok, issue;
   fetch_state_t     state, state_nxt;

   vid_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .CLOCK_50    (CLOCK_50),
      .res         (res),
      .vid_phi     (vid_phi),
      .v           (v),
      .h_nxt       (h_nxt),
      .v_nxt       (v_nxt),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .frame_start (frame_start)
   );

   // Pixel-in-cell and column counters track h without a divider.
   always_comb begin
      px_nxt  = px_q;
      col_nxt = col_q;
      if (vid_phi) begin
         if (h_nxt == '0) begin
            px_nxt  = '0;
            col_nxt = '0;
         end else if (px_q == 3'(CELL_W - 1)) begin
            px_nxt  = '0;
            col_nxt = col_q + 6'd1;
         end else begin
            px_nxt = px_q + 3'd1;
         end
      end
   end

   always_comb begin
      base_nxt = line_base;
      if (vid_phi && (h_nxt == '0)) begin
         if (v_nxt == '0)
            base_nxt = TEXT_BASE;
         else if (v_nxt[2:0] == 3'd0)
            base_nxt = line_base + 16'(COLS);
      end
   end

   assign succ_base  = (v == CNT_W'(V_TOTAL - 1)) ? TEXT_BASE :
                       (v[2:0] == 3'd7) ? line_base + 16'(COLS) : line_base;
   assign active_nxt = (h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE));
   assign cell_load  = vid_phi && active_nxt && (px_nxt == 3'd0);
   assign prefetch   = vid_phi && (h_nxt == CNT_W'(H_ACTIVE)) &&
                       ((v < CNT_W'(V_ACTIVE - 1)) || (v == CNT_W'(V_TOTAL - 1)));
   assign new_tgt    = (cell_load && (col_nxt < 6'(COLS - 1))) || prefetch;
   assign tgt_nxt    = prefetch ? succ_base : base_nxt + 16'(col_nxt) + 16'd1;

   // Handshake: vid_req rises with vid_adr already stable and both hold until
   // a cycle with vid_ack=1; vid_dbi is taken in that cycle and vid_req falls
   // after the edge. vid_ack is meaningless while vid_req is low.
   assign ack_ok = vid_ack && (state == BUSY);
   // Never issue on a cycle that retargets, so a stale address is never sent.
   assign issue  = (state == IDLE) && need_fetch && !new_tgt;

   always_ff @(posedge CLOCK_50 or posedge res) begin
      if (res) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = BUSY;
         BUSY:    if (vid_ack) state_nxt = IDLE;
                  else if (cell_load && !next_valid) state_nxt = DROP;
         DROP:    if (vid_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      vid_req     = (state == BUSY) || (state == DROP);
      fetch_state = state;
   end

   always_ff @(posedge CLOCK_50 or posedge res) begin
      if (res) begin
         px_q       <= '0;
         col_q      <= '0;
         line_base  <= TEXT_BASE;
         tgt_adr    <= TEXT_BASE + 16'd1;
         need_fetch <= 1'b1;
         vid_adr    <= TEXT_BASE;
         next_valid <= 1'b0;
         next_char  <= 8'h20;
         char_code  <= 8'h20;
         char_row   <= '0;
         char_px    <= '0;
         underrun   <= 1'b0;
      end else begin
         px_q      <= px_nxt;
         col_q     <= col_nxt;
         line_base <= base_nxt;
         if (new_tgt) begin
            tgt_adr    <= tgt_nxt;
            need_fetch <= 1'b1;
         end else if (issue) begin
            need_fetch <= 1'b0;
         end
         if (issue) vid_adr <= tgt_adr;
         if (cell_load) begin
            next_valid <= 1'b0;
            if (next_valid)
               char_code <= next_char;
            else if (ack_ok)
               char_code <= vid_dbi;
            else begin
               char_code <= 8'h20;
               underrun  <= 1'b1;
            end
         end else if (ack_ok) begin
            next_char  <= vid_dbi;
            next_valid <= 1'b1;
         end
         if (vid_phi) begin
            char_px  <= active_nxt ? px_nxt : 3'd0;
            char_row <= active_nxt ? v_nxt[2:0] : 3'd0;
         end
      end
   end
endmodule

// File: tb/tb_video_scanner.sv
// Bench for video_scanner: reduced vertical geometry and a wrapping text base,
// random pixel ticks and memory latency against a beam-position model.
module tb_video_scanner;
   localparam logic [15:0] TB_BASE = 16'hFFF0;
   localparam int HA = 280, HFP = 8, HS = 16, HBP = 16, HT = 320;
   localparam int VA = 24, VFP = 2, VS = 4, VBP = 2, VT = 32;

   logic        CLOCK_50 = 1'b0;
   logic        res = 1'b0;
   logic        vid_phi = 1'b0;
   logic        vid_ack = 1'b0;
   logic [7:0]  vid_dbi = 8'h00;
   logic [15:0] vid_adr;
   logic        vid_req;
   logic [7:0]  char_code;
   logic [2:0]  char_row, char_px;
   logic        hsync, vsync, blank, underrun, frame_start;
   logic [1:0]  fetch_state;

   int n_tests = 0;
   int n_fail  = 0;

   int mh, mv, tick_no, fs_prev, fs_seen, hs_cnt, vs_cnt;
   logic [7:0]  last_char;
   logic [15:0] exp_q[$];
   bit chk_char, chk_fetch, mem_en;
   int mem_lo, mem_hi, mem_delay, mem_cnt;

   always #5 CLOCK_50 = ~CLOCK_50;

   video_scanner #(
      .TEXT_BASE(TB_BASE),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .res         (res),
      .vid_phi     (vid_phi),
      .vid_adr     (vid_adr),
      .vid_req     (vid_req),
      .vid_ack     (vid_ack),
      .vid_dbi     (vid_dbi),
      .char_code   (char_code),
      .char_row    (char_row),
      .char_px     (char_px),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .underrun    (underrun),
      .frame_start (frame_start),
      .fetch_state (fetch_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] cell_adr(input int r, input int c);
      return TB_BASE + 16'(r * 40 + c);
   endfunction

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0];
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; tick_no = 0; fs_prev = 0; fs_seen = 0;
      hs_cnt = 0; vs_cnt = 0; mem_cnt = 0;
      last_char = 8'h20;
      exp_q.delete();
      exp_q.push_back(cell_adr(0, 1));
   endtask

   task automatic model_tick();
      bit act;
      mh++;
      if (mh == HT) begin
         mh = 0;
         mv = (mv + 1) % VT;
      end
      act = (mh < HA) && (mv < VA);
      if (act && (mh % 7 == 0)) begin
         last_char = mem_byte(cell_adr(mv / 8, mh / 7));
         if (mh / 7 < 39) exp_q.push_back(cell_adr(mv / 8, mh / 7 + 1));
      end
      if (mh == HA && (mv < VA - 1 || mv == VT - 1))
         exp_q.push_back(cell_adr(((mv + 1) % VT) / 8, 0));
      check("blank", blank, !act);
      check("hsync", hsync, !(mh >= HA + HFP && mh < HA + HFP + HS));
      check("vsync", vsync, !(mv >= VA + VFP && mv < VA + VFP + VS));
      check("char_px", char_px, act ? mh % 7 : 0);
      check("char_row", char_row, act ? mv % 8 : 0);
      tick_no++;
      if (frame_start) begin
         check("frame_ticks", tick_no - fs_prev, HT * VT);
         check("hsync_low_ticks", hs_cnt, HS * VT);
         check("vsync_low_ticks", vs_cnt, VS * HT);
         fs_seen++;
         fs_prev = tick_no;
         hs_cnt = 0;
         vs_cnt = 0;
      end
      if (!hsync) hs_cnt++;
      if (!vsync) vs_cnt++;
   endtask

   task automatic step(input logic phi);
      logic [15:0] e;
      vid_phi = phi;
      @(posedge CLOCK_50);
      #1;
      if (phi) model_tick();
      check("frame_start", frame_start, phi && mh == 0 && mv == 0);
      if (chk_char) begin
         check("char_code", char_code, last_char);
         check("underrun", underrun, 0);
      end
      if (vid_ack) begin
         vid_ack = 1'b0;
      end else if (mem_en && vid_req) begin
         mem_cnt++;
         if (mem_cnt >= mem_delay) begin
            vid_ack = 1'b1;
            vid_dbi = mem_byte(vid_adr);
            mem_cnt = 0;
            mem_delay = $urandom_range(mem_hi, mem_lo);
            if (chk_fetch) check("fetch_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (chk_fetch) check("fetch_adr", vid_adr, e);
            end
         end
      end
   endtask

   task automatic do_reset();
      vid_phi = 1'b0;
      vid_ack = 1'b0;
      res = 1'b1;
      @(posedge CLOCK_50);
      #1;
      @(posedge CLOCK_50);
      #1;
      check("rst_req", vid_req, 0);
      check("rst_adr", vid_adr, TB_BASE);
      check("rst_state", fetch_state, 0);
      check("rst_char", char_code, 8'h20);
      check("rst_row", char_row, 0);
      check("rst_px", char_px, 0);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_blank", blank, 1);
      check("rst_underrun", underrun, 0);
      check("rst_frame_start", frame_start, 0);
      res = 1'b0;
      model_reset();
   endtask

   initial begin
      int n;
      logic p;

      // Normal operation: random tick spacing, random short memory latency.
      do_reset();
      mem_en = 1; mem_lo = 1; mem_hi = 3; mem_delay = 2;
      chk_char = 1; chk_fetch = 1;
      n = 0;
      while (n < 2 * HT * VT + 50) begin
         p = ($urandom_range(0, 3) != 0);
         step(p);
         if (p) n++;
      end
      check("frame_pulses", fs_seen, 2);

      // Slow memory: every load underruns and the flag stays set.
      do_reset();
      chk_char = 0; chk_fetch = 0;
      mem_lo = 40; mem_hi = 40; mem_delay = 40;
      repeat (7) step(1'b1);
      check("ur_first_char", char_code, 8'h20);
      check("ur_first_flag", underrun, 1);
      for (int i = 0; i < 8; i++) begin
         repeat (50) step(1'b1);
         check("ur_sticky", underrun, 1);
      end

      // Reset in the middle of a handshake, then a late ack.
      do_reset();
      mem_en = 0; chk_char = 0; chk_fetch = 0;
      n = 0;
      while (!vid_req && n < 10) begin
         step(1'b0);
         n++;
      end
      check("mid_req_up", vid_req, 1);
      res = 1'b1;
      #1;
      check("mid_req_drop", vid_req, 0);
      @(posedge CLOCK_50);
      #1;
      res = 1'b0;
      model_reset();
      vid_ack = 1'b1;
      vid_dbi = 8'hAA;
      step(1'b1);
      repeat (6) step(1'b1);
      check("late_ack_char", char_code, 8'h20);
      check("late_ack_underrun", underrun, 1);

      // Ack arriving on the very cycle of a cell load.
      do_reset();
      mem_en = 0; chk_char = 0; chk_fetch = 0;
      n = 0;
      while (!vid_req && n < 10) begin
         step(1'b0);
         n++;
      end
      check("coinc_req_up", vid_req, 1);
      repeat (6) step(1'b1);
      vid_ack = 1'b1;
      vid_dbi = 8'h5A;
      step(1'b1);
      check("coinc_char", char_code, 8'h5A);
      check("coinc_underrun", underrun, 0);
      mem_en = 1; mem_lo = 1; mem_hi = 1; mem_delay = 1;
      repeat (7) step(1'b1);
      check("coinc_next_char", char_code, mem_byte(cell_adr(0, 2)));
      check("coinc_next_underrun", underrun, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
